msk_mc_column_sched: RTL and testbench

- Column-serial sequencer for the sharewise masked MixColumns core (MSKaesMC: a0..a3 in, b0..b3 out, 8*d bits each, purely combinational).
- Accepts a full masked 128-bit AES state and drives one column per cycle through a single MC core instance, writing each result back in place.
- Returns the transformed state over a valid/ready handshake.
- Sits between the SubBytes/ShiftRows stage and AddRoundKey in an area-reduced round datapath. A last-round flag bypasses MC.

---
 rtl/msk_mc_column_sched.sv | 166 ++++++++++++++++
 tb/tb_msk_mc_column_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/msk_mc_column_sched.sv
// Column-serial masked MixColumns sequencer: one column per cycle through a single share-wise MC core.
// Define MSKMC_SCHED_CLEAR_EN to wipe the state register after an output handoff with no follow-on accept.

module msk_mc_core #(
  parameter int d = 2
) (
  input  logic [8*d-1:0] a0,
  input  logic [8*d-1:0] a1,
  input  logic [8*d-1:0] a2,
  input  logic [8*d-1:0] a3,
  output logic [8*d-1:0] b0,
  output logic [8*d-1:0] b1,
  output logic [8*d-1:0] b2,
  output logic [8*d-1:0] b3
);

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns is GF(2)-linear, so each share lane is transformed on its own.
  for (genvar i = 0; i < d; i++) begin : g_share
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] r0, r1, r2, r3;

    for (genvar j = 0; j < 8; j++) begin : g_bit
      assign s0[j] = a0[d*j+i];
      assign s1[j] = a1[d*j+i];
      assign s2[j] = a2[d*j+i];
      assign s3[j] = a3[d*j+i];
      assign b0[d*j+i] = r0[j];
      assign b1[d*j+i] = r1[j];
      assign b2[d*j+i] = r2[j];
      assign b3[d*j+i] = r3[j];
    end

    assign r0 = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
    assign r1 = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
    assign r2 = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
    assign r3 = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
  end

endmodule

module msk_mc_column_sched #(
  parameter int d = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [128*d-1:0] in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*d-1:0] out_state,
  output logic             busy
);

  localparam int CW = 32*d;
  localparam int BW = 8*d;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           fsm;
  logic [1:0]       cnt;
  logic             last;
  logic [128*d-1:0] st;
  logic [128*d-1:0] st_mc;
  logic [CW-1:0]    col_in;
  logic [CW-1:0]    col_out;
  logic [BW-1:0]    b0, b1, b2, b3;

  always_comb begin
    col_in = st[0 +: CW];
    case (cnt)
      2'd0: col_in = st[0*CW +: CW];
      2'd1: col_in = st[1*CW +: CW];
      2'd2: col_in = st[2*CW +: CW];
      2'd3: col_in = st[3*CW +: CW];
      default: col_in = st[0 +: CW];
    endcase
  end

  msk_mc_core #(.d(d)) u_mc (
    .a0(col_in[0*BW +: BW]),
    .a1(col_in[1*BW +: BW]),
    .a2(col_in[2*BW +: BW]),
    .a3(col_in[3*BW +: BW]),
    .b0(b0),
    .b1(b1),
    .b2(b2),
    .b3(b3)
  );

  // Last round: the column is written back untouched so timing matches the MC path.
  assign col_out = last ? col_in : {b3, b2, b1, b0};

  always_comb begin
    st_mc = st;
    case (cnt)
      2'd0: st_mc[0*CW +: CW] = col_out;
      2'd1: st_mc[1*CW +: CW] = col_out;
      2'd2: st_mc[2*CW +: CW] = col_out;
      2'd3: st_mc[3*CW +: CW] = col_out;
      default: st_mc = st;
    endcase
  end

  assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
  assign out_state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      cnt       <= 2'd0;
      last      <= 1'b0;
      st        <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st   <= in_state;
            last <= in_last;
            cnt  <= 2'd0;
            busy <= 1'b1;
            fsm  <= RUN;
          end
        end
        RUN: begin
          st  <= st_mc;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            out_valid <= 1'b1;
            fsm       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              st   <= in_state;
              last <= in_last;
              cnt  <= 2'd0;
              fsm  <= RUN;
            end else begin
              busy <= 1'b0;
              fsm  <= IDLE;
`ifdef MSKMC_SCHED_CLEAR_EN
              st   <= '0;
`endif
            end
          end
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msk_mc_column_sched.sv
// Directed bench for msk_mc_column_sched with d=2 and FIPS-197 MixColumns vectors.
module tb_msk_mc_column_sched;

  localparam int D = 2;
  localparam int W = 128*D;

  // Byte k sits at bits [8k+7:8k]; column 0 is the low word.
  localparam logic [127:0] VAL_A = 128'h01010101_01010101_01010101_455313db;
  localparam logic [127:0] MSK_A = 128'h77777777_77777777_77777777_c33ca55a;
  localparam logic [127:0] EXP_A = 128'h01010101_01010101_01010101_bca14d8e;
  localparam logic [127:0] VAL_B = 128'hc6c6c6c6_4c31262d_d5d4d4d4_5c220af2;
  localparam logic [127:0] MSK_B = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [127:0] EXP_B = 128'hc6c6c6c6_f8bd7e4d_d6d7d5d5_9d58dc9f;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [W-1:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_state;
  logic         busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  msk_mc_column_sched #(.d(D)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_last(in_last),
    .in_state(in_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state),
    .busy(busy)
  );

  function automatic logic [W-1:0] pack(input logic [127:0] val, input logic [127:0] msk);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 8; j++) begin
        s[16*k+2*j]   = msk[8*k+j];
        s[16*k+2*j+1] = val[8*k+j] ^ msk[8*k+j];
      end
    return s;
  endfunction

  function automatic logic [127:0] unmask(input logic [W-1:0] s);
    logic [127:0] v;
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 8; j++)
        v[8*k+j] = s[16*k+2*j] ^ s[16*k+2*j+1];
    return v;
  endfunction

  function automatic logic [127:0] share0(input logic [W-1:0] s);
    logic [127:0] v;
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 8; j++)
        v[8*k+j] = s[16*k+2*j];
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one state in IDLE; returns in cycle 1 after the accept edge with in_state scrambled.
  task automatic start(input logic [W-1:0] s, input logic l);
    in_valid = 1'b1;
    in_state = s;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_state = ~s;
    in_last  = ~l;
  endtask

  // n counts cycles since the handshake cycle; a stuck DUT shows up as n==40.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_state = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (out_state !== '0) $display("FAIL reset_out_state got %h want 0", out_state); else pass_cnt++;
  endtask

  task automatic test_mix_column;
    int n;
    logic [127:0] sh;
    logic [W-1:0] prev;
    out_ready = 1'b1;
    start(pack(VAL_A, MSK_A), 1'b0);
    total_cnt++; if ({busy, in_ready} !== 2'b10) $display("FAIL mix_run_flags got busy=%b in_ready=%b want 1/0", busy, in_ready); else pass_cnt++;
    wait_valid(n);
    total_cnt++; if (n !== 5) $display("FAIL mix_latency got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (unmask(out_state) !== EXP_A) $display("FAIL mix_result got %h want %h", unmask(out_state), EXP_A); else pass_cnt++;
    sh = share0(out_state);
    total_cnt++; if (sh[127:32] !== 96'h77777777_77777777_77777777) $display("FAIL mix_share0_cols got %h want 777..7", sh[127:32]); else pass_cnt++;
    prev = out_state;
    tick();
    total_cnt++; if ({out_valid, busy, in_ready} !== 3'b001) $display("FAIL mix_after_xfer got %b want 001", {out_valid, busy, in_ready}); else pass_cnt++;
`ifdef MSKMC_SCHED_CLEAR_EN
    total_cnt++; if (out_state !== '0) $display("FAIL idle_cleared got %h want 0", out_state); else pass_cnt++;
`else
    total_cnt++; if (out_state !== prev) $display("FAIL idle_stale got %h want %h", out_state, prev); else pass_cnt++;
`endif
  endtask

  task automatic test_bypass;
    int n;
    logic [W-1:0] s;
    out_ready = 1'b1;
    s = pack(VAL_A, MSK_A);
    start(s, 1'b1);
    wait_valid(n);
    total_cnt++; if (n !== 5) $display("FAIL bypass_latency got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (out_state !== s) $display("FAIL bypass_shares got %h want %h", out_state, s); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure;
    int n;
    int xfers;
    logic [W-1:0] snap;
    out_ready = 1'b0;
    start(pack(VAL_B, MSK_B), 1'b0);
    wait_valid(n);
    total_cnt++; if (n !== 5) $display("FAIL bp_latency got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (unmask(out_state) !== EXP_B) $display("FAIL bp_result got %h want %h", unmask(out_state), EXP_B); else pass_cnt++;
    snap = out_state;
    in_valid = 1'b1;
    in_state = pack(VAL_A, MSK_A);
    for (int c = 0; c < 10; c++) begin
      tick();
      total_cnt++;
      if ({out_valid, in_ready, out_state} !== {1'b1, 1'b0, snap})
        $display("FAIL bp_hold cycle %0d got valid=%b ready=%b state=%h want 1/0/%h", c, out_valid, in_ready, out_state, snap);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_follows got %b want 1", in_ready); else pass_cnt++;
    xfers = 0;
    for (int c = 0; c < 3; c++) begin
      if (out_valid && out_ready) xfers++;
      tick();
    end
    total_cnt++; if (xfers !== 1) $display("FAIL bp_one_transfer got %0d want 1", xfers); else pass_cnt++;
    total_cnt++; if ({out_valid, busy, in_ready} !== 3'b001) $display("FAIL bp_idle got %b want 001", {out_valid, busy, in_ready}); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int n;
    logic [W-1:0] sa, sb;
    sa = pack(VAL_A, MSK_A);
    sb = pack(VAL_B, MSK_B);
    out_ready = 1'b1;
    in_valid = 1'b1; in_state = sa; in_last = 1'b1;
    tick();
    in_state = sb; in_last = 1'b0;
    wait_valid(n);
    total_cnt++; if (n !== 5) $display("FAIL b2b_first_latency got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_same_cycle_accept got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_state !== sa) $display("FAIL b2b_first_result got %h want %h", out_state, sa); else pass_cnt++;
    tick();
    in_valid = 1'b0; in_state = ~sb; in_last = 1'b1;
    total_cnt++; if ({out_valid, busy} !== 2'b01) $display("FAIL b2b_second_run got %b want 01", {out_valid, busy}); else pass_cnt++;
    wait_valid(n);
    total_cnt++; if (n !== 5) $display("FAIL b2b_spacing got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (unmask(out_state) !== EXP_B) $display("FAIL b2b_second_result got %h want %h", unmask(out_state), EXP_B); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    int n;
    out_ready = 1'b1;
    start(pack(VAL_A, MSK_A), 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL rst_run_flags got %b want 010", {out_valid, in_ready, busy}); else pass_cnt++;
    total_cnt++; if (out_state !== '0) $display("FAIL rst_run_state got %h want 0", out_state); else pass_cnt++;
    start(pack(VAL_B, MSK_B), 1'b0);
    wait_valid(n);
    total_cnt++; if (n !== 5) $display("FAIL rst_recover_latency got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (unmask(out_state) !== EXP_B) $display("FAIL rst_recover_result got %h want %h", unmask(out_state), EXP_B); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_mix_column();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
